// File: rtl/fft_peak_detect.sv
// Streaming spectral peak detector: approximate |X| = max + min/2 per FFT bin, tracks the frame maximum.
// Optional FFT_PEAK_SKIP_DC_EN: bin 0 is excluded from the peak search (still counted).
module fft_peak_detect #(
  parameter int N_POINTS = 512,
  parameter int IDX_W    = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fft_start,
  input  logic             fft_done,
  input  logic [31:0]      fft_out32,
  output logic             busy,
  output logic             peak_valid,
  output logic [IDX_W-1:0] peak_idx,
  output logic [15:0]      peak_mag,
  output logic             extra_word
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             s1_vld_q, s1_vld_d;
  logic [16:0]      s1_re_q, s1_re_d;
  logic [16:0]      s1_im_q, s1_im_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             have_q, have_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic [15:0]      peak_mag_q, peak_mag_d;
  logic             peak_valid_q, peak_valid_d;
  logic             extra_q, extra_d;

  logic [16:0] re_ext, im_ext, re_abs, im_abs;
  logic [16:0] mx, mn, mag_full;
  logic        accept, cand;

  always_comb begin
    re_ext = {fft_out32[31], fft_out32[31:16]};
    im_ext = {fft_out32[15], fft_out32[15:0]};
    re_abs = re_ext[16] ? (~re_ext + 17'd1) : re_ext;
    im_abs = im_ext[16] ? (~im_ext + 17'd1) : im_ext;
    // The top counter bit set means all N_POINTS words have been taken.
    accept = (state_q == S_ACCUM) && fft_done && !fft_start && !cnt_q[IDX_W];
    mx = (s1_re_q >= s1_im_q) ? s1_re_q : s1_im_q;
    mn = (s1_re_q >= s1_im_q) ? s1_im_q : s1_re_q;
    mag_full = mx + (mn >> 1);
`ifdef FFT_PEAK_SKIP_DC_EN
    cand = s1_vld_q && (s1_idx_q != '0);
`else
    cand = s1_vld_q;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s1_vld_d     = s1_vld_q;
    s1_re_d      = s1_re_q;
    s1_im_d      = s1_im_q;
    s1_idx_d     = s1_idx_q;
    have_d       = have_q;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = 1'b0;
    extra_d      = extra_q;
    if (fft_start) begin
      state_d    = S_ACCUM;
      cnt_d      = '0;
      s1_vld_d   = 1'b0;
      have_d     = 1'b0;
      peak_idx_d = '0;
      peak_mag_d = '0;
      extra_d    = 1'b0;
    end else begin
      s1_vld_d = accept;
      if (accept) begin
        s1_re_d  = re_abs;
        s1_im_d  = im_abs;
        s1_idx_d = cnt_q[IDX_W-1:0];
        cnt_d    = cnt_q + 1'b1;
      end
      if (fft_done && !accept) extra_d = 1'b1;
      // Strict compare keeps the lowest index on ties.
      if (cand && (!have_q || (mag_full > {1'b0, peak_mag_q}))) begin
        have_d     = 1'b1;
        peak_idx_d = s1_idx_q;
        peak_mag_d = mag_full[15:0];
      end
      if ((state_q == S_ACCUM) && s1_vld_q && (s1_idx_q == LAST_IDX)) begin
        state_d      = S_DONE;
        peak_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      s1_vld_q     <= 1'b0;
      s1_re_q      <= '0;
      s1_im_q      <= '0;
      s1_idx_q     <= '0;
      have_q       <= 1'b0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      extra_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_re_q      <= s1_re_d;
      s1_im_q      <= s1_im_d;
      s1_idx_q     <= s1_idx_d;
      have_q       <= have_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
      extra_q      <= extra_d;
    end
  end

  assign busy       = (state_q == S_ACCUM);
  assign peak_valid = peak_valid_q;
  assign peak_idx   = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign extra_word = extra_q;

endmodule
